// File: rtl/round_judge.sv
// Rock/paper/scissors round judge: captures both player choices, reports the one-hot combination,
// keeps both scores and flags the match winner. Define ROUND_JUDGE_DRAW_CNT_EN to build the draw counter.
//
// state   | meaning
// COLLECT | waiting for both players to lock a valid choice
// RESULT  | combination and scores presented, waiting for round_ack
// OVER    | a player reached WIN_SCORE, holding until new_game
module round_judge #(
  parameter int WIN_SCORE = 3,
  parameter int SCORE_W   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               new_game,
  input  logic [1:0]         p1_sel,
  input  logic               p1_lock,
  input  logic [1:0]         p2_sel,
  input  logic               p2_lock,
  input  logic               round_ack,
  output logic               p1_locked,
  output logic               p2_locked,
  output logic [8:0]         combo,
  output logic               match_over,
  output logic               p1_won,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic [3:0]         draws
);

  localparam logic [SCORE_W-1:0] WIN_S = SCORE_W'(WIN_SCORE);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    RESULT  = 2'd1,
    OVER    = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [1:0]         p1_ch, p2_ch;
  logic [1:0]         p1_ch_nxt, p2_ch_nxt;
  logic               p1_locked_nxt, p2_locked_nxt;
  logic [8:0]         combo_nxt;
  logic               match_over_nxt, p1_won_nxt;
  logic [SCORE_W-1:0] p1_score_nxt, p2_score_nxt;

  logic               p1_acc, p2_acc;
  logic               enter_result;
  logic               p1_win, p2_win;
  logic [3:0]         combo_idx;
  logic [8:0]         combo_hot;

  // Choices are only ever 0..2 once captured, so the index stays within 0..8.
  assign combo_idx = 4'(p1_ch) * 4'd3 + 4'(p2_ch);
  assign combo_hot = 9'd1 << combo_idx;

  assign p1_win = (p1_ch == 2'd1 && p2_ch == 2'd0) ||
                  (p1_ch == 2'd2 && p2_ch == 2'd1) ||
                  (p1_ch == 2'd0 && p2_ch == 2'd2);
  assign p2_win = (p2_ch == 2'd1 && p1_ch == 2'd0) ||
                  (p2_ch == 2'd2 && p1_ch == 2'd1) ||
                  (p2_ch == 2'd0 && p1_ch == 2'd2);

  assign p1_acc = (state == COLLECT) && p1_lock && !p1_locked && (p1_sel != 2'd3);
  assign p2_acc = (state == COLLECT) && p2_lock && !p2_locked && (p2_sel != 2'd3);
  assign enter_result = (state == COLLECT) && p1_locked && p2_locked && !new_game;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= COLLECT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (new_game) begin
      state_nxt = COLLECT;
    end else begin
      case (state)
        COLLECT: if (p1_locked && p2_locked) state_nxt = RESULT;
        RESULT:  if (round_ack) state_nxt = match_over ? OVER : COLLECT;
        OVER:    state_nxt = OVER;
        default: state_nxt = COLLECT;
      endcase
    end
  end

  always_comb begin
    p1_ch_nxt      = p1_ch;
    p2_ch_nxt      = p2_ch;
    p1_locked_nxt  = p1_locked;
    p2_locked_nxt  = p2_locked;
    combo_nxt      = combo;
    match_over_nxt = match_over;
    p1_won_nxt     = p1_won;
    p1_score_nxt   = p1_score;
    p2_score_nxt   = p2_score;
    if (new_game) begin
      p1_ch_nxt      = 2'd0;
      p2_ch_nxt      = 2'd0;
      p1_locked_nxt  = 1'b0;
      p2_locked_nxt  = 1'b0;
      combo_nxt      = 9'd0;
      match_over_nxt = 1'b0;
      p1_won_nxt     = 1'b0;
      p1_score_nxt   = '0;
      p2_score_nxt   = '0;
    end else begin
      if (p1_acc) begin
        p1_ch_nxt     = p1_sel;
        p1_locked_nxt = 1'b1;
      end
      if (p2_acc) begin
        p2_ch_nxt     = p2_sel;
        p2_locked_nxt = 1'b1;
      end
      if (enter_result) begin
        combo_nxt = combo_hot;
        if (p1_win && p1_score != WIN_S) p1_score_nxt = p1_score + SCORE_W'(1);
        if (p2_win && p2_score != WIN_S) p2_score_nxt = p2_score + SCORE_W'(1);
        match_over_nxt = (p1_score_nxt == WIN_S) || (p2_score_nxt == WIN_S);
        p1_won_nxt     = (p1_score_nxt == WIN_S);
      end
      if (state == RESULT && round_ack) begin
        combo_nxt     = 9'd0;
        p1_locked_nxt = 1'b0;
        p2_locked_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p1_ch      <= 2'd0;
      p2_ch      <= 2'd0;
      p1_locked  <= 1'b0;
      p2_locked  <= 1'b0;
      combo      <= 9'd0;
      match_over <= 1'b0;
      p1_won     <= 1'b0;
      p1_score   <= '0;
      p2_score   <= '0;
    end else begin
      p1_ch      <= p1_ch_nxt;
      p2_ch      <= p2_ch_nxt;
      p1_locked  <= p1_locked_nxt;
      p2_locked  <= p2_locked_nxt;
      combo      <= combo_nxt;
      match_over <= match_over_nxt;
      p1_won     <= p1_won_nxt;
      p1_score   <= p1_score_nxt;
      p2_score   <= p2_score_nxt;
    end
  end

`ifdef ROUND_JUDGE_DRAW_CNT_EN
  logic [3:0] draw_q;

  // Consecutive draws: bumps on each drawn round, cleared by any decisive one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      draw_q <= 4'd0;
    end else if (new_game) begin
      draw_q <= 4'd0;
    end else if (enter_result) begin
      if (p1_win || p2_win)    draw_q <= 4'd0;
      else if (draw_q != 4'hf) draw_q <= draw_q + 4'd1;
    end
  end

  assign draws = draw_q;
`else
  assign draws = 4'd0;
`endif

endmodule

// File: tb/tb_round_judge.sv
// Scoreboard bench for round_judge: directed rounds push expected results, a negedge monitor
// pops and compares each time a new combination appears.
module tb_round_judge;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       new_game = 1'b0;
  logic [1:0] p1_sel = 2'd0;
  logic       p1_lock = 1'b0;
  logic [1:0] p2_sel = 2'd0;
  logic       p2_lock = 1'b0;
  logic       round_ack = 1'b0;
  logic       p1_locked, p2_locked, match_over, p1_won;
  logic [8:0] combo;
  logic [1:0] p1_score, p2_score;
  logic [3:0] draws;

  round_judge #(.WIN_SCORE(3), .SCORE_W(2)) dut (
    .clk(clk), .reset(reset), .new_game(new_game),
    .p1_sel(p1_sel), .p1_lock(p1_lock), .p2_sel(p2_sel), .p2_lock(p2_lock),
    .round_ack(round_ack), .p1_locked(p1_locked), .p2_locked(p2_locked),
    .combo(combo), .match_over(match_over), .p1_won(p1_won),
    .p1_score(p1_score), .p2_score(p2_score), .draws(draws)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [8:0] combo;
    logic [1:0] s1;
    logic [1:0] s2;
    logic       mo;
    logic       pw;
    logic [3:0] dr;
    int         at;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_err = 0;
  int n_res = 0;
  logic [8:0] prev_combo = 9'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] edr(input logic [3:0] v);
`ifdef ROUND_JUDGE_DRAW_CNT_EN
    return v;
`else
    return 4'd0 & v;
`endif
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    chk("combo_onehot", 32'($countones(combo) > 1), 32'd0);
    if (combo != 9'd0 && prev_combo == 9'd0) begin
      n_res++;
      if (q.size() == 0) begin
        chk("unexpected_result", 32'(combo), 32'd0);
      end else begin
        e = q.pop_front();
        chk("res_combo", 32'(combo), 32'(e.combo));
        chk("res_p1_score", 32'(p1_score), 32'(e.s1));
        chk("res_p2_score", 32'(p2_score), 32'(e.s2));
        chk("res_match_over", 32'(match_over), 32'(e.mo));
        chk("res_p1_won", 32'(p1_won), 32'(e.pw));
        chk("res_draws", 32'(draws), 32'(e.dr));
        chk("res_cycle", 32'(cyc), 32'(e.at));
      end
    end
    prev_combo = combo;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lock(input logic l1, input logic [1:0] s1, input logic l2, input logic [1:0] s2);
    p1_lock = l1; p1_sel = s1; p2_lock = l2; p2_sel = s2;
    tick();
    p1_lock = 1'b0; p2_lock = 1'b0;
  endtask

  // Called right after the edge that completed both locks; result is due one edge later.
  task automatic expect_result(input logic [8:0] c, input logic [1:0] s1, input logic [1:0] s2,
                               input logic mo, input logic pw, input logic [3:0] dr);
    exp_t e;
    int start;
    e.combo = c; e.s1 = s1; e.s2 = s2; e.mo = mo; e.pw = pw; e.dr = edr(dr); e.at = cyc + 1;
    q.push_back(e);
    start = n_res;
    for (int i = 0; i < 20 && n_res == start; i++) tick();
    if (n_res == start) chk("result_timeout", 32'd0, 32'd1);
  endtask

  task automatic ack();
    round_ack = 1'b1;
    tick();
    round_ack = 1'b0;
  endtask

  task automatic pulse_new_game();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
  endtask

  function automatic logic [31:0] all_out();
    return 32'({p1_locked, p2_locked, combo, match_over, p1_won, p1_score, p2_score, draws});
  endfunction

  initial begin
    #2;
    chk("reset_outputs", all_out(), 32'd0);
    #15;
    reset = 1'b1;
    tick();

    // P1 paper locks first, P2 rock three cycles later
    lock(1'b1, 2'd1, 1'b0, 2'd0);
    chk("p1_locked_rise", 32'(p1_locked), 32'd1);
    chk("p2_locked_idle", 32'(p2_locked), 32'd0);
    tick(); tick();
    lock(1'b0, 2'd0, 1'b1, 2'd0);
    chk("p2_locked_rise", 32'(p2_locked), 32'd1);
    expect_result(9'b000001000, 2'd1, 2'd0, 1'b0, 1'b0, 4'd0);
    ack();
    chk("ack_combo_clear", 32'(combo), 32'd0);
    chk("ack_locks_clear", 32'({p1_locked, p2_locked}), 32'd0);

    // invalid p1 selection ignored, p2 relock ignored, rock vs rock draw
    lock(1'b1, 2'd3, 1'b1, 2'd0);
    chk("invalid_sel_ignored", 32'(p1_locked), 32'd0);
    chk("p2_first_lock", 32'(p2_locked), 32'd1);
    lock(1'b0, 2'd0, 1'b1, 2'd2);
    lock(1'b1, 2'd0, 1'b0, 2'd0);
    expect_result(9'b000000001, 2'd1, 2'd0, 1'b0, 1'b0, 4'd1);
    ack();

    // simultaneous scissors vs scissors, second consecutive draw
    lock(1'b1, 2'd2, 1'b1, 2'd2);
    expect_result(9'b100000000, 2'd1, 2'd0, 1'b0, 1'b0, 4'd2);
    ack();

    // P2 paper beats rock three times
    lock(1'b1, 2'd0, 1'b1, 2'd1);
    expect_result(9'b000000010, 2'd1, 2'd1, 1'b0, 1'b0, 4'd0);
    ack();
    lock(1'b1, 2'd0, 1'b1, 2'd1);
    expect_result(9'b000000010, 2'd1, 2'd2, 1'b0, 1'b0, 4'd0);
    ack();
    lock(1'b1, 2'd0, 1'b1, 2'd1);
    expect_result(9'b000000010, 2'd1, 2'd3, 1'b1, 1'b0, 4'd0);
    lock(1'b1, 2'd1, 1'b1, 2'd2);
    tick();
    chk("result_hold_combo", 32'(combo), 32'h002);
    chk("result_hold_scores", 32'({p1_score, p2_score}), 32'({2'd1, 2'd3}));
    ack();
    chk("over_combo", 32'(combo), 32'd0);
    chk("over_flags", 32'({match_over, p1_won}), 32'b10);
    lock(1'b1, 2'd0, 1'b1, 2'd1);
    tick(); tick();
    ack();
    tick();
    chk("over_hold_scores", 32'({p1_score, p2_score}), 32'({2'd1, 2'd3}));
    chk("over_hold_flags", 32'({match_over, p1_won, combo}), 32'({1'b1, 1'b0, 9'd0}));
    pulse_new_game();
    chk("new_game_clear", all_out(), 32'd0);

    // new_game beats round_ack in RESULT
    lock(1'b1, 2'd1, 1'b1, 2'd0);
    expect_result(9'b000001000, 2'd1, 2'd0, 1'b0, 1'b0, 4'd0);
    new_game = 1'b1; round_ack = 1'b1;
    tick();
    new_game = 1'b0; round_ack = 1'b0;
    chk("ng_ack_clear", all_out(), 32'd0);

    lock(1'b1, 2'd2, 1'b1, 2'd1);
    expect_result(9'b010000000, 2'd1, 2'd0, 1'b0, 1'b0, 4'd0);

    // asynchronous reset in the middle of RESULT
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_now", all_out(), 32'd0);
    tick();
    chk("async_reset_held", all_out(), 32'd0);
    reset = 1'b1;
    tick();

    // P1 rock beats scissors to a match win
    lock(1'b1, 2'd0, 1'b1, 2'd2);
    expect_result(9'b000000100, 2'd1, 2'd0, 1'b0, 1'b0, 4'd0);
    ack();
    lock(1'b1, 2'd0, 1'b1, 2'd2);
    expect_result(9'b000000100, 2'd2, 2'd0, 1'b0, 1'b0, 4'd0);
    ack();
    lock(1'b1, 2'd0, 1'b1, 2'd2);
    expect_result(9'b000000100, 2'd3, 2'd0, 1'b1, 1'b1, 4'd0);
    ack();
    chk("p1_match_flags", 32'({match_over, p1_won, combo}), 32'({1'b1, 1'b1, 9'd0}));

    tick();
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/round_judge.md
# round_judge

Game datapath block that produces the status signals the game controller FSM consumes. It collects each player's character selection and judges the round as rock/paper/scissors. It reports the one-hot 3x3 combination, keeps both scores, and flags the end of the match and its winner. It sits between the player input decoders and the controller: its `combo` outputs drive the controller's nine combination inputs, `match_over` drives the win check, and `p1_won` drives the winner select.

## Interface
- `WIN_SCORE`, default 3: points needed to win the match.
- `SCORE_W`, default 2: score register width; must satisfy 2^SCORE_W > WIN_SCORE.

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `new_game`  in  1  synchronous clear of scores and round; one-cycle pulse from the controller's start state.
- `p1_sel`  in  2  player 1 selection: 0 rock, 1 paper, 2 scissors, 3 invalid.
- `p1_lock`  in  1  player 1 lock-in strobe.
- `p2_sel`  in  2  player 2 selection, same encoding as `p1_sel`.
- `p2_lock`  in  1  player 2 lock-in strobe.
- `round_ack`  in  1  controller has consumed the round result.
- `p1_locked`  out  1  player 1 choice captured this round.
- `p2_locked`  out  1  player 2 choice captured this round.
- `combo`  out  9  one-hot round combination; index = p1*3 + p2.
- `match_over`  out  1  a score has reached `WIN_SCORE`.
- `p1_won`  out  1  player 1 is the match winner; valid only while `match_over` is 1.
- `p1_score`  out  SCORE_W  player 1 score.
- `p2_score`  out  SCORE_W  player 2 score.
- `draws`  out  4  consecutive-draw count (see Configuration).

## Operation
- States: COLLECT, RESULT, OVER. Reset state is COLLECT.
- Reset values: all outputs 0, captured choices 0.
- COLLECT:
  - A player's lock with a valid selection (0..2) captures that selection and sets that player's `pN_locked`.
  - A lock with selection 3 is ignored.
  - Once a player is locked, further locks from that player are ignored for the rest of the round.
  - Both players may lock in the same cycle.
- When both players are locked, the block moves to RESULT. On that transition edge it:
  - drives `combo` one-hot;
  - judges the round: P1 wins if (p1 − p2) mod 3 == 1, P2 wins if (p2 − p1) mod 3 == 1, otherwise it is a draw;
  - increments the round winner's score, saturating at `WIN_SCORE`;
  - sets `match_over` if either score equals `WIN_SCORE`, and sets `p1_won` = (`p1_score` == `WIN_SCORE`).
- RESULT holds `combo` and the scores stable until `round_ack`. Then:
  - if `match_over` is 0, the block clears `combo` and both locks and returns to COLLECT;
  - if `match_over` is 1, the block goes to OVER.
- Lock strobes are ignored in RESULT and OVER.
- OVER holds scores, `match_over`, `p1_won` and `combo` = 0 until `new_game`.
- `new_game` in any state:
  - clears scores, locks, `combo`, `match_over`, `p1_won` and `draws`;
  - goes to COLLECT next cycle;
  - has priority over locks and `round_ack` in the same cycle.
- `round_ack` outside RESULT is ignored.

## Timing
- Combination latency: the second lock at edge N gives `combo` and the updated scores valid after edge N+1. The whole result is registered; there are no combinational paths from inputs to outputs.
- `pN_locked` rises one cycle after the accepted lock.
- `round_ack` at edge M clears `combo` and the locks after edge M (or moves to OVER after edge M). A lock arriving in cycle M is dropped.
- `combo` is never multi-hot. It is all-zero outside RESULT.
- An asynchronous reset in any state returns the block to COLLECT with all outputs 0 immediately, independent of `clk`.

## Configuration
- `ROUND_JUDGE_DRAW_CNT_EN` defined:
  - `draws` counts consecutive draws, updated on entry to RESULT;
  - it saturates at 15;
  - it clears on any decisive round, on `new_game`, and on reset.
- Not defined: `draws` is tied to 0 and no counter logic is built. All other behaviour is identical.

## Test plan
- Reset low mid-RESULT: all outputs 0 immediately; state COLLECT after release.
- `p1_sel`=1 lock at cycle 2, `p2_sel`=0 lock at cycle 5 → after the next edge, `combo`=9'b000001000, `p1_score`=1, `p2_score`=0, `match_over`=0; `round_ack` → `combo`=0 and both locks cleared.
- Simultaneous locks, `p1_sel`=2 and `p2_sel`=2 → `combo`=9'b100000000, scores unchanged; with the macro, `draws`=1, and a second draw gives `draws`=2.
- `p1_sel`=3 lock → `p1_locked` stays 0; a repeated `p2_lock` with a different selection after the first → the first choice is retained.
- P2 wins three rounds of rock vs paper (`combo`=9'b000000010) → `p2_score`=3, `match_over`=1, `p1_won`=0; `round_ack` → OVER, locks ignored; `new_game` → all cleared.
- `new_game` and `round_ack` in the same cycle in RESULT → scores 0, state COLLECT.
